// File: rtl/regfile_mp_if.sv
// Bundles the scrub control, two read ports and two write ports of regfile_mp.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic            clr_req;
    logic            busy;
    logic            clr_done;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wa_we;
    logic            wb_we;
    logic [AW-1:0]   wa_addr;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wa_data;
    logic [XLEN-1:0] wb_data;

    modport master (
        output clr_req, rs1_addr, rs2_addr,
        output wa_we, wb_we, wa_addr, wb_addr, wa_data, wb_data,
        input  busy, clr_done, rs1_data, rs2_data
    );

    modport slave (
        input  clr_req, rs1_addr, rs2_addr,
        input  wa_we, wb_we, wa_addr, wb_addr, wa_data, wb_data,
        output busy, clr_done, rs1_data, rs2_data
    );
endinterface

// File: rtl/regfile_mp.sv
// Two-read / two-write register file with hardwired-zero r0, write-to-read
// bypass and a sequential scrub engine that also clears the array after reset.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic {IDLE, SCRUB} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   cnt, cnt_next;
    logic            clr_done_q;
    logic [XLEN-1:0] regs [NREGS];
    logic            busy;

    assign busy         = (state == SCRUB);
    assign bus.busy     = busy;
    assign bus.clr_done = clr_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SCRUB;
            cnt        <= AW'(1);
            clr_done_q <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            clr_done_q <= (state == SCRUB) && (cnt == LAST);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_next = SCRUB;
                    cnt_next   = AW'(1);
                end
            end
            SCRUB: begin
                if (cnt == LAST) begin
                    state_next = IDLE;
                    cnt_next   = AW'(1);
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            default: begin
                state_next = SCRUB;
                cnt_next   = AW'(1);
            end
        endcase
    end

    // Array has no reset; the post-reset scrub is what clears it.
    // Port B is written after port A so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (busy) begin
            regs[cnt] <= '0;
        end else begin
            if (bus.wa_we && (bus.wa_addr != '0)) regs[bus.wa_addr] <= bus.wa_data;
            if (bus.wb_we && (bus.wb_addr != '0)) regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        bus.rs1_data = '0;
        if (!busy && (bus.rs1_addr != '0)) begin
            if (bus.wb_we && (bus.wb_addr == bus.rs1_addr))
                bus.rs1_data = bus.wb_data;
            else if (bus.wa_we && (bus.wa_addr == bus.rs1_addr))
                bus.rs1_data = bus.wa_data;
            else
                bus.rs1_data = regs[bus.rs1_addr];
        end
    end

    always_comb begin
        bus.rs2_data = '0;
        if (!busy && (bus.rs2_addr != '0)) begin
            if (bus.wb_we && (bus.wb_addr == bus.rs2_addr))
                bus.rs2_data = bus.wb_data;
            else if (bus.wa_we && (bus.wa_addr == bus.rs2_addr))
                bus.rs2_data = bus.wa_data;
            else
                bus.rs2_data = regs[bus.rs2_addr];
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Randomized scoreboard bench for regfile_mp against a behavioural model of
// the register file and its scrub/reset timing.
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int              sel;   // 0 rs1_data, 1 rs2_data, 2 busy, 3 clr_done
        logic [XLEN-1:0] exp;
    } exp_t;

    exp_t q [$];
    int   applied    = 0;
    int   miscompares = 0;

    // Reference model: a busy flag plus a count of scrub edges still owed.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy;
    int              m_left;
    bit              m_done;

    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
        if (m_busy || a == 0) return '0;
        if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
        if (bus.wa_we && bus.wa_addr == a) return bus.wa_data;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        m_busy = 1'b1;
        m_left = NREGS - 1;
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        bit done_n;
        done_n = m_busy && (m_left == 1);
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            end
        end else begin
            if (bus.wa_we && bus.wa_addr != 0) m_regs[bus.wa_addr] = bus.wa_data;
            if (bus.wb_we && bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
            if (bus.clr_req) begin
                m_busy = 1'b1;
                m_left = NREGS - 1;
            end
        end
        m_done = done_n;
    endtask

    // Push this cycle's expectations, then advance one clock edge.
    task automatic cycle();
        if (rst) model_reset();
        q.push_back('{0, m_read(bus.rs1_addr)});
        q.push_back('{1, m_read(bus.rs2_addr)});
        q.push_back('{2, XLEN'(m_busy)});
        q.push_back('{3, XLEN'(m_done)});
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.clr_req = 1'b0;
        bus.wa_we   = 1'b0;
        bus.wb_we   = 1'b0;
        bus.wa_addr = '0;
        bus.wb_addr = '0;
        bus.wa_data = '0;
        bus.wb_data = '0;
    endtask

    task automatic rand_writes();
        bus.wa_we   = $urandom_range(0, 1) == 1;
        bus.wb_we   = $urandom_range(0, 1) == 1;
        bus.wa_addr = AW'($urandom);
        bus.wb_addr = ($urandom_range(0, 3) == 0) ? bus.wa_addr : AW'($urandom);
        bus.wa_data = $urandom;
        bus.wb_data = $urandom;
        bus.rs1_addr = ($urandom_range(0, 2) == 0) ? bus.wa_addr : AW'($urandom);
        bus.rs2_addr = ($urandom_range(0, 2) == 0) ? bus.wb_addr : AW'($urandom);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [XLEN-1:0] act;
            e = q.pop_front();
            case (e.sel)
                0:       act = bus.rs1_data;
                1:       act = bus.rs2_data;
                2:       act = XLEN'(bus.busy);
                default: act = XLEN'(bus.clr_done);
            endcase
            applied++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s at %0t: got %h expected %h",
                         e.sel == 0 ? "rs1_data" : e.sel == 1 ? "rs2_data" :
                         e.sel == 2 ? "busy" : "clr_done", $time, act, e.exp);
            end
        end
    end

    initial begin
        idle_inputs();
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset, then a full post-reset scrub with idle inputs.
        repeat (2) cycle();
        rst = 1'b0;
        for (int i = 0; i < NREGS + 2; i++) begin
            bus.rs1_addr = AW'($urandom);
            bus.rs2_addr = AW'($urandom);
            cycle();
        end

        // Port A write with same-cycle bypass, then registered read.
        bus.wa_we = 1'b1; bus.wa_addr = 5; bus.wa_data = 32'hDEADBEEF;
        bus.rs1_addr = 5;
        cycle();
        idle_inputs();
        cycle();

        // Both ports hit address 7; port B wins.
        bus.wa_we = 1'b1; bus.wa_addr = 7; bus.wa_data = 32'h11;
        bus.wb_we = 1'b1; bus.wb_addr = 7; bus.wb_data = 32'h22;
        bus.rs2_addr = 7;
        cycle();
        idle_inputs();
        cycle();

        // Writes to r0 are discarded.
        bus.wa_we = 1'b1; bus.wa_addr = 0; bus.wa_data = '1;
        bus.wb_we = 1'b1; bus.wb_addr = 0; bus.wb_data = '1;
        bus.rs1_addr = 0;
        cycle();
        idle_inputs();
        cycle();

        // Random traffic with occasional scrub requests.
        for (int i = 0; i < 200; i++) begin
            rand_writes();
            bus.clr_req = $urandom_range(0, 39) == 0;
            cycle();
        end
        idle_inputs();
        while (m_busy) cycle();

        // Fill registers, then scrub while hammering the write ports.
        for (int i = 1; i < NREGS; i++) begin
            bus.wa_we = 1'b1; bus.wa_addr = AW'(i); bus.wa_data = $urandom | 1;
            bus.rs1_addr = AW'(i); bus.rs2_addr = AW'(i - 1);
            cycle();
        end
        idle_inputs();
        bus.clr_req = 1'b1;
        cycle();
        for (int i = 0; i < NREGS + 2; i++) begin
            rand_writes();
            bus.clr_req = $urandom_range(0, 1) == 1;
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < NREGS; i += 2) begin
            bus.rs1_addr = AW'(i); bus.rs2_addr = AW'(i + 1);
            cycle();
        end

        // Reset arriving at scrub edge 10 restarts the scrub.
        bus.clr_req = 1'b1;
        cycle();
        bus.clr_req = 1'b0;
        repeat (10) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        for (int i = 0; i < NREGS + 3; i++) begin
            bus.rs1_addr = AW'($urandom);
            bus.rs2_addr = AW'($urandom);
            cycle();
        end

        // Short random tail after the reset-driven scrub.
        for (int i = 0; i < 40; i++) begin
            rand_writes();
            cycle();
        end
        idle_inputs();
        cycle();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
